// File: rtl/ctrl_pkg.sv
// Shared types and constants for the Genesis pad reader: scan phases and
// the bit positions of the published button word.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_P0,
        ST_P1,
        ST_P2,
        ST_P3,
        ST_P4,
        ST_P5,
        ST_P6,
        ST_P7
    } phase_t;

    localparam int unsigned BTN_W     = 11;
    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;
    localparam int unsigned BTN_A     = 4;
    localparam int unsigned BTN_B     = 5;
    localparam int unsigned BTN_C     = 6;
    localparam int unsigned BTN_START = 7;
    localparam int unsigned BTN_X     = 8;
    localparam int unsigned BTN_Y     = 9;
    localparam int unsigned BTN_Z     = 10;

endpackage

// File: rtl/ctrl_sync.sv
// Parameterised-width two-flop synchroniser with asynchronous active-low
// reset and a per-instance reset value.
module ctrl_sync #(
    parameter int unsigned   W       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/genesis_controller.sv
// Sega Genesis pad scanner: one select/sample sequence per vga_vs rising edge.
// Define CTRL_SIX_BUTTON_EN for the 8-phase scan with X/Y/Z; otherwise P0..P3.
module genesis_controller
    import ctrl_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 500
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             up_z,
    input  logic             down_y,
    input  logic             left_x,
    input  logic             right,
    input  logic             a_b,
    input  logic             start_c,
    input  logic             vga_vs,
    output logic             selectSignal,
    output logic [BTN_W-1:0] buttonsOut
);

    localparam int unsigned    CW       = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STEP_CYCLES - 1);
`ifdef CTRL_SIX_BUTTON_EN
    localparam phase_t         LAST_PH  = ST_P7;
`else
    localparam phase_t         LAST_PH  = ST_P3;
`endif

    // Pin vector order: {start_c, a_b, right, left_x, down_y, up_z}
    logic [5:0]       w_pins_s;
    logic [5:0]       w_pins;
    logic             w_vs_s;
    logic             w_vs_rise;
    logic             w_last;
    logic             w_sel;
    phase_t           r_state;
    phase_t           w_next;
    logic             r_vs_d;
    logic [CW-1:0]    r_cnt;
    logic [BTN_W-1:0] r_shadow;
    logic [BTN_W-1:0] r_out;
`ifdef CTRL_SIX_BUTTON_EN
    logic             r_six;
`endif

    ctrl_sync #(.W(6), .RST_VAL(6'b111111)) u_pin_sync (
        .clk   (clk),
        .rst_n (reset),
        .i_d   ({start_c, a_b, right, left_x, down_y, up_z}),
        .o_q   (w_pins_s)
    );

    ctrl_sync #(.W(1), .RST_VAL(1'b0)) u_vs_sync (
        .clk   (clk),
        .rst_n (reset),
        .i_d   (vga_vs),
        .o_q   (w_vs_s)
    );

    assign w_pins    = ~w_pins_s;
    assign w_vs_rise = w_vs_s & ~r_vs_d;
    assign w_last    = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (r_state == ST_IDLE) begin
            if (w_vs_rise) w_next = ST_P0;
        end else if (w_last) begin
            w_next = (r_state == LAST_PH) ? ST_IDLE : phase_t'(r_state + 4'd1);
        end
    end

    always_comb begin
        w_sel = 1'b1;
        case (r_state)
            ST_P1, ST_P3, ST_P5, ST_P7: w_sel = 1'b0;
            default:                    w_sel = 1'b1;
        endcase
    end

    assign selectSignal = w_sel;
    assign buttonsOut   = r_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vs_d   <= 1'b0;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_out    <= '0;
`ifdef CTRL_SIX_BUTTON_EN
            r_six    <= 1'b0;
`endif
        end else begin
            r_vs_d <= w_vs_s;
            if (r_state == ST_IDLE || w_last) r_cnt <= '0;
            else                              r_cnt <= r_cnt + CW'(1);

            if (r_state != ST_IDLE && w_last) begin
                case (r_state)
                    ST_P0: begin
                        r_shadow[BTN_UP]    <= w_pins[0];
                        r_shadow[BTN_DOWN]  <= w_pins[1];
                        r_shadow[BTN_LEFT]  <= w_pins[2];
                        r_shadow[BTN_RIGHT] <= w_pins[3];
                        r_shadow[BTN_B]     <= w_pins[4];
                        r_shadow[BTN_C]     <= w_pins[5];
                    end
                    ST_P1: begin
                        r_shadow[BTN_A]     <= w_pins[4];
                        r_shadow[BTN_START] <= w_pins[5];
                    end
`ifdef CTRL_SIX_BUTTON_EN
                    ST_P5: r_six <= &w_pins[3:0];
                    ST_P6: begin
                        r_shadow[BTN_Z] <= r_six & w_pins[0];
                        r_shadow[BTN_Y] <= r_six & w_pins[1];
                        r_shadow[BTN_X] <= r_six & w_pins[2];
                    end
`endif
                    default: ;
                endcase
                // Whole word moves at scan end so the output never shows a partial scan.
                if (r_state == LAST_PH) r_out <= r_shadow;
            end
        end
    end

endmodule

// File: tb/tb_genesis_controller.sv
// Directed bench for genesis_controller: a pad model answers the select line
// and each scan's word and latency are checked against hand-computed values.
module tb_genesis_controller;

    localparam int STEP = 4;
`ifdef CTRL_SIX_BUTTON_EN
    localparam int NPH = 8;
    localparam logic [10:0] EXP_SIX = 11'h500;
`else
    localparam int NPH = 4;
    localparam logic [10:0] EXP_SIX = 11'h000;
`endif
    localparam int LAT = NPH * STEP + 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        up_z = 1'b1, down_y = 1'b1, left_x = 1'b1, right = 1'b1;
    logic        a_b = 1'b1, start_c = 1'b1, vga_vs = 1'b0;
    logic        selectSignal;
    logic [10:0] buttonsOut;

    int n_cmp = 0;
    int n_err = 0;
    int mode  = 0;
    int ph    = 0;
    logic last_sel = 1'b1;
    logic saw_low;

    genesis_controller #(.STEP_CYCLES(STEP)) dut (
        .clk          (clk),
        .reset        (reset),
        .up_z         (up_z),
        .down_y       (down_y),
        .left_x       (left_x),
        .right        (right),
        .a_b          (a_b),
        .start_c      (start_c),
        .vga_vs       (vga_vs),
        .selectSignal (selectSignal),
        .buttonsOut   (buttonsOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pad model: phase index follows select toggles, wrapping each scan.
    always @(negedge clk) begin
        if (!reset) begin
            ph       = 0;
            last_sel = 1'b1;
        end else if (selectSignal !== last_sel) begin
            last_sel = selectSignal;
            ph       = (ph + 1) % NPH;
        end
        up_z = 1'b1; down_y = 1'b1; left_x = 1'b1; right = 1'b1;
        a_b  = 1'b1; start_c = 1'b1;
        case (mode)
            1: up_z = 1'b0;
            2: if (selectSignal) start_c = 1'b0; else a_b = 1'b0;
            3: begin
                if (ph == 5) begin up_z = 1'b0; down_y = 1'b0; left_x = 1'b0; right = 1'b0; end
                if (ph == 6) begin up_z = 1'b0; left_x = 1'b0; end
            end
            4: begin
                if (ph == 0) a_b = 1'b0;
                if (ph == 6) begin up_z = 1'b0; down_y = 1'b0; left_x = 1'b0; end
            end
            default: ;
        endcase
    end

    // again > 0 issues a second vga_vs pulse at that cycle of the scan.
    task automatic scan(input string tag, input logic [10:0] old_w,
                        input logic [10:0] exp_w, input int again);
        @(negedge clk);
        vga_vs = 1'b1;
        for (int i = 1; i < LAT; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) vga_vs = 1'b0;
            if (again > 0 && i == again) vga_vs = 1'b1;
            if (again > 0 && i == again + 2) vga_vs = 1'b0;
            if (i == STEP + 4) check({tag, "_sel_mid"}, {10'd0, selectSignal}, 11'd0);
        end
        check({tag, "_hold"}, buttonsOut, old_w);
        @(posedge clk);
        #1;
        check(tag, buttonsOut, exp_w);
        check({tag, "_sel_end"}, {10'd0, selectSignal}, 11'd1);
    endtask

    task automatic idle_watch(input int cycles);
        saw_low = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (selectSignal !== 1'b1) saw_low = 1'b1;
        end
    endtask

    initial begin
        #1 reset = 1'b0;
        #19;
        check("rst_out", buttonsOut, 11'h000);
        check("rst_sel", {10'd0, selectSignal}, 11'd1);
        @(negedge clk);
        check("rst_out2", buttonsOut, 11'h000);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_out", buttonsOut, 11'h000);
        check("idle_sel", {10'd0, selectSignal}, 11'd1);

        mode = 1;
        scan("up", 11'h000, 11'h001, 0);
        mode = 0;
        idle_watch(20);
        check("up_hold_after", buttonsOut, 11'h001);
        check("no_spont_scan", {10'd0, saw_low}, 11'd0);

        mode = 2;
        scan("a_c", 11'h001, 11'h050, 0);

        mode = 3;
        scan("six_btn", 11'h050, EXP_SIX, 0);

        mode = 4;
        scan("three_btn", EXP_SIX, 11'h020, 0);

        mode = 1;
        scan("midscan_vs", 11'h020, 11'h001, 10);
        idle_watch(LAT + 5);
        check("no_restart", {10'd0, saw_low}, 11'd0);
        check("no_restart_out", buttonsOut, 11'h001);

        mode = 2;
        @(negedge clk);
        vga_vs = 1'b1;
        repeat (3) @(posedge clk);
        #1 vga_vs = 1'b0;
        repeat (STEP + 3) @(posedge clk);
        #1;
        check("abort_sel_pre", {10'd0, selectSignal}, 11'd0);
        reset = 1'b0;
        #1;
        check("abort_out", buttonsOut, 11'h000);
        check("abort_sel", {10'd0, selectSignal}, 11'd1);
        @(negedge clk);
        reset = 1'b1;
        idle_watch(LAT + 5);
        check("abort_no_publish", buttonsOut, 11'h000);
        check("abort_no_scan", {10'd0, saw_low}, 11'd0);

        scan("recover", 11'h000, 11'h050, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
